cudacore_issue_unit: RTL and testbench

Host-side issue/collect unit that sits on the other end of the cudacore operand/result interface.
- Accepts operations from an upstream scheduler on a valid/ready stream.
- Drives registered operands, opcode and an issue strobe into the core.
- Captures the core's result strobes into an in-order result FIFO, which a downstream consumer drains via valid/ready.
- The core has no backpressure, so a credit scheme guarantees every in-flight result has a FIFO slot.

---
 rtl/cudacore_issue_unit.sv | 157 +++++++++++++++
 tb/tb_cudacore_issue_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cudacore_issue_unit.sv
// ---------------------------------------------------------------------------
// cudacore_issue_unit
//
// Host-side issue/collect unit for the cudacore operand/result interface.
// Operations arrive on a valid/ready stream and are sent to the core as
// registered operands plus a one-cycle issue strobe. Results coming back on
// the core's strobe are stored in an in-order FIFO, which a consumer drains
// with valid/ready. The core cannot stall, so the unit only accepts an
// operation when a FIFO slot is reserved for its result (credit scheme).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready          upstream operation handshake
//   s_dataA/s_dataB/s_opcode upstream operands and opcode
//   core_dataA/B/opcode      registered operands/opcode to the core
//   core_ctrl                one-cycle issue strobe to the core
//   core_rdata/core_rctrl    result data and result strobe from the core
//   m_valid/m_ready/m_data   result stream to the consumer (FIFO head)
//   idle                     all credits free and no issue pending
//   err_unexpected           sticky: result strobe that could not be accepted
// ---------------------------------------------------------------------------
module cudacore_issue_unit #(
    parameter int DATA_W    = 32,
    parameter int OP_W      = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_dataA,
    input  logic [DATA_W-1:0] s_dataB,
    input  logic [OP_W-1:0]   s_opcode,
    output logic [DATA_W-1:0] core_dataA,
    output logic [DATA_W-1:0] core_dataB,
    output logic [OP_W-1:0]   core_opcode,
    output logic              core_ctrl,
    input  logic [DATA_W-1:0] core_rdata,
    input  logic              core_rctrl,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              idle,
    output logic              err_unexpected
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RES_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    logic [CNT_W-1:0]  credits_reg, credits_next;
    logic [CNT_W-1:0]  in_flight_reg, in_flight_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [DATA_W-1:0] mem_reg [RES_DEPTH];
    logic [DATA_W-1:0] m_data_reg;
    logic [DATA_W-1:0] dataA_reg, dataB_reg;
    logic [OP_W-1:0]   opcode_reg;
    logic              ctrl_reg;
    logic              err_reg, err_next;

    logic accept, pop, rsp_valid, fifo_full, push, overflow, head_bypass;

    assign s_ready   = (credits_reg != '0);
    assign accept    = s_valid && s_ready;
    assign pop       = (count_reg != '0) && m_ready;
    assign fifo_full = (count_reg == DEPTH_CNT);

    // A result strobe is legitimate only if something is in flight; an issue
    // strobe in the same cycle counts (zero-latency core).
    assign rsp_valid = core_rctrl && ((in_flight_reg != '0) || ctrl_reg);
    // A full FIFO can still take a result when the head leaves this cycle.
    assign push      = rsp_valid && (!fifo_full || pop);
    assign overflow  = rsp_valid && fifo_full && !pop;

    assign rd_ptr_next = pop  ? rd_ptr_reg + ONE_PTR : rd_ptr_reg;
    assign wr_ptr_next = push ? wr_ptr_reg + ONE_PTR : wr_ptr_reg;
    // The incoming result becomes the new head when it is written to the
    // slot the read pointer lands on (FIFO empty, or one entry being popped).
    assign head_bypass = push && (wr_ptr_reg == rd_ptr_next);

    always_comb begin
        credits_next = credits_reg;
        case ({accept, pop})
            2'b10:   credits_next = credits_reg - ONE_CNT;
            2'b01:   credits_next = credits_reg + ONE_CNT;
            default: credits_next = credits_reg;
        endcase

        in_flight_next = in_flight_reg;
        case ({ctrl_reg, rsp_valid})
            2'b10:   in_flight_next = in_flight_reg + ONE_CNT;
            2'b01:   in_flight_next = in_flight_reg - ONE_CNT;
            default: in_flight_next = in_flight_reg;
        endcase

        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + ONE_CNT;
            2'b01:   count_next = count_reg - ONE_CNT;
            default: count_next = count_reg;
        endcase

        err_next = err_reg || (core_rctrl && !rsp_valid) || overflow;
    end

    // Result storage: plain array without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= core_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_reg   <= DEPTH_CNT;
            in_flight_reg <= '0;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            m_data_reg    <= '0;
            dataA_reg     <= '0;
            dataB_reg     <= '0;
            opcode_reg    <= '0;
            ctrl_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            credits_reg   <= credits_next;
            in_flight_reg <= in_flight_next;
            count_reg     <= count_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            err_reg       <= err_next;
            ctrl_reg      <= accept;
            if (accept) begin
                dataA_reg  <= s_dataA;
                dataB_reg  <= s_dataB;
                opcode_reg <= s_opcode;
            end
            // Registered head read at the next read address.
            m_data_reg <= head_bypass ? core_rdata : mem_reg[rd_ptr_next];
        end
    end

    assign core_dataA     = dataA_reg;
    assign core_dataB     = dataB_reg;
    assign core_opcode    = opcode_reg;
    assign core_ctrl      = ctrl_reg;
    assign m_valid        = (count_reg != '0);
    assign m_data         = m_data_reg;
    assign idle           = (credits_reg == DEPTH_CNT) && !ctrl_reg;
    assign err_unexpected = err_reg;

endmodule

// File: tb/tb_cudacore_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_cudacore_issue_unit
//
// Bench for cudacore_issue_unit. A behavioural core returns f(A,B,op) in
// issue order after a configurable latency. A queue-based reference tracks
// outstanding operations, buffered results and the error flag; every cycle
// all DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_cudacore_issue_unit;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_dataA = '0;
    logic [DW-1:0] s_dataB = '0;
    logic [OW-1:0] s_opcode = '0;
    logic [DW-1:0] core_dataA, core_dataB;
    logic [OW-1:0] core_opcode;
    logic          core_ctrl;
    logic [DW-1:0] core_rdata = '0;
    logic          core_rctrl = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          idle;
    logic          err_unexpected;

    always #5 clk = ~clk;

    cudacore_issue_unit #(.DATA_W(DW), .OP_W(OW), .RES_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_dataA(s_dataA), .s_dataB(s_dataB), .s_opcode(s_opcode),
        .core_dataA(core_dataA), .core_dataB(core_dataB),
        .core_opcode(core_opcode), .core_ctrl(core_ctrl),
        .core_rdata(core_rdata), .core_rctrl(core_rctrl),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .idle(idle), .err_unexpected(err_unexpected)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state
    int            outstanding = 0;   // accepted, not yet popped
    int            inflight = 0;      // issued to core, result not returned
    bit            exp_ctrl = 0;
    logic [DW-1:0] exp_a = '0, exp_b = '0;
    logic [OW-1:0] exp_op = '0;
    logic [DW-1:0] fifo_q[$];
    bit            exp_err = 0;

    // Behavioural core
    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } rsp_t;
    rsp_t core_q[$];
    int   cyc = 0;
    int   last_due = -1;
    int   lat_min = 1, lat_max = 1;
    bit   inject = 0;

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic [OW-1:0] op);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [OW-1:0] op,
                        input bit rdy, input bit r);
        bit   acc, pop, rv, push;
        int   lat, due;
        rsp_t e;
        s_valid = v; s_dataA = a; s_dataB = b; s_opcode = op;
        m_ready = rdy; rst = r;
        core_rctrl = 1'b0;
        core_rdata = $urandom;
        if (inject) begin
            core_rctrl = 1'b1;
        end else if (core_q.size() > 0 && core_q[0].due <= cyc) begin
            core_rctrl = 1'b1;
            core_rdata = core_q[0].d;
            void'(core_q.pop_front());
        end
        acc  = v && (outstanding < D) && !r;
        pop  = rdy && (fifo_q.size() > 0);
        rv   = core_rctrl && (inflight > 0 || exp_ctrl);
        push = rv && (fifo_q.size() < D || pop);
        @(posedge clk);
        if (r) begin
            outstanding = 0; inflight = 0; exp_ctrl = 0;
            exp_a = '0; exp_b = '0; exp_op = '0;
            fifo_q.delete();
            exp_err = 0;
        end else begin
            if (core_rctrl && !rv) exp_err = 1;
            if (rv && !push) exp_err = 1;
            if (pop) begin
                $display("[TB] cyc %0d pop result %08h", cyc, fifo_q[0]);
                void'(fifo_q.pop_front());
            end
            if (push) fifo_q.push_back(core_rdata);
            outstanding += int'(acc) - int'(pop);
            inflight    += int'(exp_ctrl) - int'(rv);
            exp_ctrl = acc;
            if (acc) begin
                exp_a = a; exp_b = b; exp_op = op;
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + 1 + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.d = core_fn(a, b, op);
                e.due = due;
                core_q.push_back(e);
            end
        end
        cyc++;
        #1;
        check_val("s_ready", 32'(s_ready), 32'(outstanding < D));
        check_val("core_ctrl", 32'(core_ctrl), 32'(exp_ctrl));
        check_val("core_dataA", core_dataA, exp_a);
        check_val("core_dataB", core_dataB, exp_b);
        check_val("core_opcode", 32'(core_opcode), 32'(exp_op));
        check_val("m_valid", 32'(m_valid), 32'(fifo_q.size() > 0));
        if (fifo_q.size() > 0) check_val("m_data", m_data, fifo_q[0]);
        if (r) check_val("m_data_rst", m_data, 32'h0);
        check_val("idle", 32'(idle), 32'(outstanding == 0 && !exp_ctrl));
        check_val("err_unexpected", 32'(err_unexpected), 32'(exp_err));
    endtask

    task automatic idle_steps(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 4'($urandom), rdy, 1'b0);
    endtask

    initial begin
        // Reset
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);

        // Single op: 5 + 7, result three cycles after the issue strobe
        lat_min = 3; lat_max = 3;
        step(1'b1, 32'd5, 32'd7, 4'h0, 1'b0, 1'b0);
        check_val("single_issue_A", core_dataA, 32'd5);
        idle_steps(4, 1'b0);
        check_val("single_result", m_data, 32'd12);
        idle_steps(2, 1'b1);
        check_val("single_idle", 32'(idle), 32'd1);

        // Credit exhaustion with the consumer stalled
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);
        idle_steps(10, 1'b0);
        check_val("exhaust_ready", 32'(s_ready), 32'd0);
        idle_steps(1, 1'b1);
        step(1'b1, 32'd100, 32'd1, 4'h1, 1'b0, 1'b0);
        idle_steps(20, 1'b1);

        // Full-rate stream, latency 2, consumer always ready
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i), 32'(i), 4'($urandom), 1'b1, 1'b0);
        idle_steps(10, 1'b1);

        // Random traffic, variable latency including zero
        lat_min = 0; lat_max = 4;
        for (int i = 0; i < 500; i++)
            step(1'($urandom), $urandom, $urandom, 4'($urandom),
                 ($urandom_range(3, 0) != 0), 1'b0);
        idle_steps(30, 1'b1);
        check_val("drain_empty", 32'(m_valid), 32'd0);

        // Spurious result strobe with nothing in flight
        inject = 1;
        idle_steps(1, 1'b1);
        inject = 0;
        check_val("proto_err", 32'(err_unexpected), 32'd1);
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 4'($urandom), 1'b1, 1'b0);
        idle_steps(10, 1'b1);
        check_val("proto_err_sticky", 32'(err_unexpected), 32'd1);

        // Reset with three operations in flight; late results flag an error
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        check_val("rst_idle", 32'(idle), 32'd1);
        idle_steps(12, 1'b1);
        check_val("late_rsp_err", 32'(err_unexpected), 32'd1);

        core_q.delete();
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 40; i++)
            step(1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom), 1'b0);
        idle_steps(20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
